dmem_arbiter: RTL and testbench

Shares the single-port SISC data memory between two requesters: the core load/store path (c_*) and a program/debug loader (l_*). Both requesters use a req/ack handshake. The block arbitrates between them, sequences one memory access at a time with a parameterised read latency, and returns read data with a one-cycle ack. It sits between the core datapath/loader and the data memory and replaces the direct dm_we/address hookup.

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: shares the single-port data memory between core and loader.
// clk/rst; c_*/l_* req/ack requesters; mem_* strobed memory port.
module dmem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int DEPTH    = 256,
  parameter int MEM_LAT  = 1,
  parameter int CORE_PRI = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_ack,
  output logic          c_err,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_ack,
  output logic          l_err,
  output logic [DW-1:0] l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [3:0]  LAT_V   = 4'(MEM_LAT);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          own_q, own_d;
  logic          last_q, last_d;
  logic          oor_q, oor_d;
  logic          wr_q, wr_d;
  logic          en_d, we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic [DW-1:0] crd_d, lrd_d;

  logic          pick_l;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [DW-1:0] sel_wdata;
  logic          sel_ok;
  logic [DW-1:0] cap;

  // own/last: 1 = loader, 0 = core
  always_comb begin
    unique case (1'b1)
      c_req && l_req:  pick_l = (CORE_PRI == 0) && !last_q;
      l_req && !c_req: pick_l = 1'b1;
      default:         pick_l = 1'b0;
    endcase
  end

  assign sel_addr  = pick_l ? l_addr : c_addr;
  assign sel_we    = pick_l ? l_we : c_we;
  assign sel_wdata = pick_l ? l_wdata : c_wdata;
  assign sel_ok    = {1'b0, sel_addr} < DEPTH_V;
  // out-of-range accesses return zero
  assign cap       = oor_q ? '0 : mem_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    last_d  = last_q;
    oor_d   = oor_q;
    wr_d    = wr_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    crd_d   = c_rdata;
    lrd_d   = l_rdata;
    unique case (state_q)
      IDLE: begin
        if (c_req || l_req) begin
          state_d = ACCESS;
          cnt_d   = LAT_V;
          own_d   = pick_l;
          last_d  = pick_l;
          oor_d   = !sel_ok;
          wr_d    = sel_we;
          en_d    = sel_ok;
          we_d    = sel_ok && sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          if (oor_q || !wr_q) begin
            if (own_q) lrd_d = cap;
            else       crd_d = cap;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      own_q     <= 1'b0;
      last_q    <= 1'b1;
      oor_q     <= 1'b0;
      wr_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      c_rdata   <= '0;
      l_rdata   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      own_q     <= own_d;
      last_q    <= last_d;
      oor_q     <= oor_d;
      wr_q      <= wr_d;
      mem_en    <= en_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      c_rdata   <= crd_d;
      l_rdata   <= lrd_d;
    end
  end

  assign c_gnt = (state_q != IDLE) && !own_q;
  assign l_gnt = (state_q != IDLE) && own_q;
  assign c_ack = (state_q == DONE) && !own_q;
  assign l_ack = (state_q == DONE) && own_q;
  assign c_err = c_ack && oor_q;
  assign l_err = l_ack && oor_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// tb_dmem_arbiter: two arbiters (lat1/round-robin, lat3/core-priority)
// on shared requester stimulus, each with its own memory model.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam logic [DW-1:0] BAD = 32'hBAD0BAD0;

  typedef struct {
    bit          ldr;
    bit          err;
    logic [DW-1:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic c_req = 1'b0, c_we = 1'b0;
  logic l_req = 1'b0, l_we = 1'b0;
  logic [AW-1:0] c_addr = '0, l_addr = '0;
  logic [DW-1:0] c_wdata = '0, l_wdata = '0;

  logic c_gnt[2], c_ack[2], c_err[2];
  logic l_gnt[2], l_ack[2], l_err[2];
  logic [DW-1:0] c_rdata[2], l_rdata[2];
  logic mem_en[2], mem_we[2];
  logic [AW-1:0] mem_addr[2];
  logic [DW-1:0] mem_wdata[2], mem_rdata[2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_LAT(1), .CORE_PRI(0)) u0 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt[0]), .c_ack(c_ack[0]), .c_err(c_err[0]),
    .c_rdata(c_rdata[0]),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt[0]), .l_ack(l_ack[0]), .l_err(l_err[0]),
    .l_rdata(l_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  dmem_arbiter #(.MEM_LAT(3), .CORE_PRI(1)) u1 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt[1]), .c_ack(c_ack[1]), .c_err(c_err[1]),
    .c_rdata(c_rdata[1]),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt[1]), .l_ack(l_ack[1]), .l_err(l_err[1]),
    .l_rdata(l_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // memory model: data is driven only inside the exact latency window
  logic [DW-1:0] tbmem [256];
  logic [7:0]    age1;
  logic [AW-1:0] laddr1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age1   <= 8'd0;
      laddr1 <= '0;
    end else if (mem_en[1] && !mem_we[1]) begin
      age1   <= 8'd1;
      laddr1 <= mem_addr[1];
    end else if (age1 != 8'd0) begin
      age1 <= age1 + 8'd1;
    end
  end

  always_comb begin
    mem_rdata[0] = BAD;
    mem_rdata[1] = BAD;
    if (mem_en[0] && !mem_we[0])
      mem_rdata[0] = tbmem[mem_addr[0][7:0]];
    if (age1 == 8'd2)
      mem_rdata[1] = tbmem[laddr1[7:0]];
  end

  // scoreboard
  exp_t sb0[$];
  exp_t sb1[$];
  logic [DW-1:0] mdl_crd[2], mdl_lrd[2];
  int cyc = 0;
  int gstart[2];
  bit gprev[2];

  always @(negedge clk) begin
    exp_t e;
    bit ok;
    int lat;
    logic gerr, oerr;
    logic [DW-1:0] grd;
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if ((c_gnt[d] || l_gnt[d]) && !gprev[d]) gstart[d] = cyc;
      gprev[d] = c_gnt[d] || l_gnt[d];
      checks++;
      if ((c_gnt[d] && l_gnt[d]) || (mem_we[d] && !mem_en[d])) begin
        failures++;
        $display("FAIL bus_excl dut%0d: gnt c/l=%b/%b en=%b we=%b",
                 d, c_gnt[d], l_gnt[d], mem_en[d], mem_we[d]);
      end
      if (c_ack[d] || l_ack[d]) begin
        ok = (d == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL sb_unexpected dut%0d: ack c/l=%b/%b, none expected",
                   d, c_ack[d], l_ack[d]);
        end else begin
          if (d == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          gerr = e.ldr ? l_err[d] : c_err[d];
          oerr = e.ldr ? c_err[d] : l_err[d];
          grd  = e.ldr ? l_rdata[d] : c_rdata[d];
          lat  = cyc - gstart[d];
          if (l_ack[d] !== e.ldr || c_ack[d] !== !e.ldr ||
              gerr !== e.err || oerr !== 1'b0 || grd !== e.rd ||
              lat != ((d == 0) ? 1 : 3)) begin
            failures++;
            $display("FAIL sb_ack dut%0d: ldr=%b err=%b rd=%h lat=%0d, required ldr=%b err=%b rd=%h lat=%0d",
                     d, l_ack[d], gerr, grd, lat,
                     e.ldr, e.err, e.rd, (d == 0) ? 1 : 3);
          end
        end
      end
    end
  end

  int en_cnt[2], en_k[2], ack_k[2];
  logic [AW-1:0] en_addr[2];
  logic en_we[2];
  logic [DW-1:0] en_wd[2];

  task automatic expect_acc(input int d, input bit ldr, input bit err,
                            input logic [DW-1:0] rd);
    exp_t e;
    e.ldr = ldr;
    e.err = err;
    e.rd  = rd;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    if (ldr) mdl_lrd[d] = rd;
    else     mdl_crd[d] = rd;
  endtask

  // steps n cycles recording strobe/ack timing; optionally drops both
  // requests once the faster arbiter acks
  task automatic run(input int n, input bit drop);
    for (int d = 0; d < 2; d++) begin
      en_cnt[d] = 0; en_k[d] = 0; ack_k[d] = 0;
      en_addr[d] = '0; en_we[d] = 1'b0; en_wd[d] = '0;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (mem_en[d]) begin
          en_cnt[d]++;
          if (en_k[d] == 0) begin
            en_k[d] = k;
            en_addr[d] = mem_addr[d];
            en_we[d] = mem_we[d];
            en_wd[d] = mem_wdata[d];
          end
        end
        if ((c_ack[d] || l_ack[d]) && ack_k[d] == 0) ack_k[d] = k;
      end
      if (drop && (c_ack[0] || l_ack[0])) begin
        c_req = 1'b0;
        l_req = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mdl_crd[d] = '0;
      mdl_lrd[d] = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      mdl_crd[d] = '0;
      mdl_lrd[d] = '0;
      checks++;
      if ({c_gnt[d], l_gnt[d], c_ack[d], l_ack[d], c_err[d], l_err[d],
           mem_en[d], mem_we[d]} !== 8'h00) begin
        failures++;
        $display("FAIL reset_ctl dut%0d: gnt=%b%b ack=%b%b en=%b, required 0",
                 d, c_gnt[d], l_gnt[d], c_ack[d], l_ack[d], mem_en[d]);
      end
      checks++;
      if (mem_addr[d] !== '0 || mem_wdata[d] !== '0) begin
        failures++;
        $display("FAIL reset_bus dut%0d: addr=%h wdata=%h, required 0",
                 d, mem_addr[d], mem_wdata[d]);
      end
      checks++;
      if (c_rdata[d] !== mdl_crd[d] || l_rdata[d] !== mdl_lrd[d]) begin
        failures++;
        $display("FAIL reset_rdata dut%0d: c=%h l=%h, required 0",
                 d, c_rdata[d], l_rdata[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_core_read();
    for (int d = 0; d < 2; d++) expect_acc(d, 1'b0, 1'b0, 32'hDEADBEEF);
    c_we = 1'b0;
    c_addr = 16'h0010;
    c_req = 1'b1;
    run(8, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (en_cnt[d] != 1 || en_k[d] != 1) begin
        failures++;
        $display("FAIL core_rd_en dut%0d: cnt=%0d at=%0d, required 1 at 1",
                 d, en_cnt[d], en_k[d]);
      end
      checks++;
      if (en_addr[d] !== 16'h0010 || en_we[d] !== 1'b0) begin
        failures++;
        $display("FAIL core_rd_bus dut%0d: addr=%h we=%b, required 0010/0",
                 d, en_addr[d], en_we[d]);
      end
      checks++;
      if (ack_k[d] != ((d == 0) ? 2 : 4)) begin
        failures++;
        $display("FAIL core_rd_ack dut%0d: ack at %0d, required %0d",
                 d, ack_k[d], (d == 0) ? 2 : 4);
      end
    end
  endtask

  task automatic test_loader();
    for (int d = 0; d < 2; d++) expect_acc(d, 1'b1, 1'b0, tbmem[8'h30]);
    l_we = 1'b0;
    l_addr = 16'h0030;
    l_req = 1'b1;
    run(8, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ack_k[d] != ((d == 0) ? 2 : 4)) begin
        failures++;
        $display("FAIL ldr_rd_ack dut%0d: ack at %0d, required %0d",
                 d, ack_k[d], (d == 0) ? 2 : 4);
      end
    end
    for (int d = 0; d < 2; d++) expect_acc(d, 1'b1, 1'b0, mdl_lrd[d]);
    l_we = 1'b1;
    l_addr = 16'h0020;
    l_wdata = 32'h12345678;
    l_req = 1'b1;
    run(8, 1'b1);
    l_we = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (en_cnt[d] != 1 || en_we[d] !== 1'b1 || en_addr[d] !== 16'h0020 ||
          en_wd[d] !== 32'h12345678) begin
        failures++;
        $display("FAIL ldr_wr_bus dut%0d: cnt=%0d we=%b addr=%h wd=%h, required 1/1/0020/12345678",
                 d, en_cnt[d], en_we[d], en_addr[d], en_wd[d]);
      end
      checks++;
      if (ack_k[d] != ((d == 0) ? 2 : 4)) begin
        failures++;
        $display("FAIL ldr_wr_ack dut%0d: ack at %0d, required %0d",
                 d, ack_k[d], (d == 0) ? 2 : 4);
      end
      checks++;
      if (c_rdata[d] !== mdl_crd[d]) begin
        failures++;
        $display("FAIL c_rdata_hold dut%0d: got %h, required %h",
                 d, c_rdata[d], mdl_crd[d]);
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int d = 0; d < 2; d++) expect_acc(d, 1'b0, 1'b1, '0);
    c_we = 1'b0;
    c_addr = 16'h0100;
    c_req = 1'b1;
    run(8, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (en_cnt[d] != 0) begin
        failures++;
        $display("FAIL oor_en dut%0d: mem_en cycles=%0d, required 0",
                 d, en_cnt[d]);
      end
      checks++;
      if (ack_k[d] != ((d == 0) ? 2 : 4)) begin
        failures++;
        $display("FAIL oor_ack dut%0d: ack at %0d, required %0d",
                 d, ack_k[d], (d == 0) ? 2 : 4);
      end
      checks++;
      if (l_rdata[d] !== mdl_lrd[d]) begin
        failures++;
        $display("FAIL l_rdata_hold dut%0d: got %h, required %h",
                 d, l_rdata[d], mdl_lrd[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0, n1, ng;
    int gk[4];
    bit p0;
    do_reset();
    expect_acc(0, 1'b0, 1'b0, 32'hDEADBEEF);
    expect_acc(0, 1'b1, 1'b0, tbmem[8'h30]);
    expect_acc(0, 1'b0, 1'b0, 32'hDEADBEEF);
    expect_acc(0, 1'b1, 1'b0, tbmem[8'h30]);
    for (int i = 0; i < 3; i++) expect_acc(1, 1'b0, 1'b0, 32'hDEADBEEF);
    n0 = 0; n1 = 0; ng = 0; p0 = 1'b0;
    for (int i = 0; i < 4; i++) gk[i] = 0;
    c_we = 1'b0; c_addr = 16'h0010;
    l_we = 1'b0; l_addr = 16'h0030;
    c_req = 1'b1;
    l_req = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if ((c_gnt[0] || l_gnt[0]) && !p0) begin
        if (ng < 4) gk[ng] = k;
        ng++;
      end
      p0 = c_gnt[0] || l_gnt[0];
      if (c_ack[0] || l_ack[0]) n0++;
      if (c_ack[1] || l_ack[1]) n1++;
      if (n0 == 4) begin
        c_req = 1'b0;
        l_req = 1'b0;
      end
    end
    c_req = 1'b0;
    l_req = 1'b0;
    checks++;
    if (n0 != 4 || n1 != 3) begin
      failures++;
      $display("FAIL tie_count: acks dut0=%0d dut1=%0d, required 4/3", n0, n1);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (gk[i] - gk[i-1] != 3) begin
        failures++;
        $display("FAIL b2b_spacing grant%0d: gap=%0d, required 3",
                 i, gk[i] - gk[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    c_we = 1'b1;
    c_addr = 16'h0040;
    c_wdata = 32'hCAFEF00D;
    c_req = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mem_en[d] !== 1'b1 || mem_we[d] !== 1'b1) begin
        failures++;
        $display("FAIL mid_pre dut%0d: en=%b we=%b, required 1/1",
                 d, mem_en[d], mem_we[d]);
      end
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({mem_en[d], mem_we[d], c_gnt[d], c_ack[d]} !== 4'b0000) begin
        failures++;
        $display("FAIL mid_rst dut%0d: en=%b we=%b gnt=%b ack=%b, required 0",
                 d, mem_en[d], mem_we[d], c_gnt[d], c_ack[d]);
      end
    end
    c_req = 1'b0;
    c_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mdl_crd[d] = '0;
      mdl_lrd[d] = '0;
    end
    for (int d = 0; d < 2; d++) expect_acc(d, 1'b0, 1'b0, 32'hDEADBEEF);
    c_addr = 16'h0010;
    l_we = 1'b0;
    l_addr = 16'h0030;
    c_req = 1'b1;
    l_req = 1'b1;
    run(8, 1'b1);
    c_req = 1'b0;
    l_req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ack_k[d] != ((d == 0) ? 2 : 4)) begin
        failures++;
        $display("FAIL post_rst_ack dut%0d: ack at %0d, required %0d",
                 d, ack_k[d], (d == 0) ? 2 : 4);
      end
    end
  endtask

  task automatic test_drain();
    repeat (6) @(negedge clk);
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: pending dut0=%0d dut1=%0d, required 0/0",
               sb0.size(), sb1.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbmem[i] = 32'hA5A50000 | i;
    tbmem[8'h10] = 32'hDEADBEEF;
    test_reset();
    test_core_read();
    test_loader();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
